// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and default operand width.
// The ALU top level imports this package too, so the encodings stay in one place.
package shift_add_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Parallel_Adder: the ALU's WIDTH-bit ripple-carry adder, reused by the multiplier as its only adder.
module Parallel_Adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one shared adder, one add-and-shift step per clock,
// start/busy/done handshake, product register holding the last completed result.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    mult_state_t state;
    mult_state_t next_state;

    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH:0]   shifted;

    assign addend = q[0] ? m : '0;

    // C is cleared on load and by every shift, so the carry-in is always zero here.
    Parallel_Adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc),
        .b    (addend),
        .cin  (c),
        .sum  (sum),
        .cout (cout)
    );

    assign shifted = {cout, sum, q} >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The final iteration writes product from the same shifted value that lands in {Acc,Q}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        c   <= 1'b0;
                        cnt <= CNT_LOAD;
                    end
                end
                RUN: begin
                    c   <= shifted[2*WIDTH];
                    acc <= shifted[2*WIDTH-1:WIDTH];
                    q   <= shifted[WIDTH-1:0];
                    if (cnt == '0) begin
                        product <= shifted[2*WIDTH-1:0];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed handshake cases plus random operands
// compared against plain a*b, with latency, busy width and product-hold checks on every run.
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int edge_count = 0;
    int accept_edge = 0;
    logic [15:0] held_product = '0;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_count++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one request at a negedge and returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [7:0] op_a, input logic [7:0] op_b);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom_range(0, 255));
        b     = 8'($urandom_range(0, 255));
        accept_edge = edge_count;
    endtask

    // Waits (bounded) for done, checking product holds its old value and counting busy samples.
    task automatic waitDone(input string tag, output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cycles++;
            checkOutput({tag, "_hold"}, 32'(product), 32'(held_product));
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic runMultiply(input string tag, input logic [7:0] op_a, input logic [7:0] op_b);
        int busy_cycles;
        logic [15:0] expected;
        expected = 16'(op_a) * 16'(op_b);
        applyStimulus(op_a, op_b);
        checkOutput({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        waitDone(tag, busy_cycles);
        checkOutput({tag, "_latency"}, 32'(edge_count - accept_edge), 32'd8);
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd8);
        checkOutput({tag, "_product"}, 32'(product), 32'(expected));
        checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        held_product = expected;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cycles;
        int done_hits;
        int last_done_edge;
        logic [7:0] ra;
        logic [7:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        checkOutput("reset_product", 32'(product), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        runMultiply("basic_0f_01", 8'h0F, 8'h01);
        runMultiply("carry_ff_ff", 8'hFF, 8'hFF);
        runMultiply("aa_55", 8'hAA, 8'h55);
        runMultiply("zero_00_37", 8'h00, 8'h37);

        // A second request during RUN must be dropped entirely.
        applyStimulus(8'h02, 8'h03);
        @(posedge clk);
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waitDone("ignored_start", busy_cycles);
        checkOutput("ignored_start_latency", 32'(edge_count - accept_edge), 32'd8);
        checkOutput("ignored_start_product", 32'(product), 32'h0006);
        held_product = 16'h0006;
        done_hits = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) done_hits++;
        end
        checkOutput("ignored_start_no_second_done", 32'(done_hits), 32'd0);
        checkOutput("ignored_start_product_hold", 32'(product), 32'h0006);

        // Asynchronous reset in the middle of an operation, between clock edges.
        applyStimulus(8'hFF, 8'hFF);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_product", 32'(product), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        held_product = 16'h0000;
        @(negedge clk);
        checkOutput("after_rst_idle_busy", 32'(busy), 32'd0);
        runMultiply("after_rst_0c_0a", 8'h0C, 8'h0A);

        // start held high: one result every WIDTH+2 cycles, accepts only from IDLE.
        a     = 8'h10;
        b     = 8'h10;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        accept_edge = edge_count;
        waitDone("held_start_first", busy_cycles);
        checkOutput("held_start_first_latency", 32'(edge_count - accept_edge), 32'd8);
        checkOutput("held_start_first_product", 32'(product), 32'h0100);
        held_product = 16'h0100;
        last_done_edge = edge_count;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("held_start_idle_gap_busy", 32'(busy), 32'd0);
            checkOutput("held_start_idle_gap_done", 32'(done), 32'd0);
            waitDone("held_start_repeat", busy_cycles);
            checkOutput("held_start_interval", 32'(edge_count - last_done_edge), 32'd10);
            checkOutput("held_start_busy_cycles", 32'(busy_cycles), 32'd8);
            checkOutput("held_start_product", 32'(product), 32'h0100);
            last_done_edge = edge_count;
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);

        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            runMultiply("random", ra, rb);
        end
        runMultiply("edge_ff_01", 8'hFF, 8'h01);
        runMultiply("edge_80_80", 8'h80, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
